pp_pipeline_accel_udiv_22ns_11ns_seq: RTL
=========================================

// Module: pp_pipeline_accel_udiv_22ns_11ns_seq
// PURPOSE
//  Iterative unsigned restoring divider: 22-bit dividend / 11-bit divisor -> 22-bit quotient + 11-bit remainder.
//  Inverse-direction companion to the 11x11->22 DSP multiplier in pp_pipeline_accel; computes resize scale
//  factors and normalisation reciprocals. One quotient bit per cycle, valid/ready on both sides.
// PARAMETERS
//  DIVIDEND_W  22  dividend and quotient width; equals the iteration count
//  DIVISOR_W   11  divisor and remainder width
// PORTS
//  ap_clk       in   1           clock; all state updates on rising edge
//  ap_rst_n     in   1           asynchronous, active-low reset
//  in_valid     in   1           operand pair valid
//  in_ready     out  1           divider can accept operands
//  in_dividend  in   DIVIDEND_W  unsigned dividend
//  in_divisor   in   DIVISOR_W   unsigned divisor
//  out_valid    out  1           result valid
//  out_ready    in   1           consumer accepts result
//  out_quot     out  DIVIDEND_W  unsigned quotient
//  out_rem      out  DIVISOR_W   unsigned remainder
//  out_dbz      out  1           divisor was zero
// BEHAVIOUR
//  - Reset (ap_rst_n=0, async): state=IDLE; out_valid=0, out_quot=0, out_rem=0, out_dbz=0, iter count=0.
//    in_ready=0 while ap_rst_n low; 1 from the first edge after release.
//  - FSM: IDLE -(in_valid&&in_ready)-> BUSY -(count==DIVIDEND_W-1)-> DONE -(out_ready)-> IDLE,
//    or DONE -(out_ready&&in_valid)-> BUSY directly (back-to-back).
//  - in_ready = IDLE || (DONE && out_ready). Operands latched only on in_valid&&in_ready.
//  - Latency: accept at edge E0 -> out_valid rises at edge E0+DIVIDEND_W. Constant for every operand,
//    including divisor zero. Throughput 1 op per DIVIDEND_W+1 cycles with out_ready held high.
//  - Step (BUSY, MSB first): t={rem,dvd[msb]} (DIVISOR_W+1 bits); if t>=divisor: rem=t-divisor, qbit=1;
//    else rem=t[DIVISOR_W-1:0], qbit=0; dividend shift register shifts left, qbit enters quotient LSB.
//    rem register holds DIVISOR_W bits; t carries the extra bit so no overflow.
//  - Divisor zero: out_dbz=1, out_quot={DIVIDEND_W{1'b1}}, out_rem=in_dividend[DIVISOR_W-1:0].
//    Data path still runs DIVIDEND_W cycles; results forced at DONE entry.
//  - out_valid, out_quot, out_rem, out_dbz are registers; stable while out_valid && !out_ready.
//  - out_valid deasserts the edge after out_valid&&out_ready unless a new op completes the same edge
//    (impossible: minimum gap is DIVIDEND_W cycles).
//  - in_valid during BUSY: ignored, not latched; the upstream holds it.
//  - Reset mid-operation: in-flight op discarded, no result emitted; IDLE after release.
//  - No X propagation: quotient/remainder registers reset, not only valid.
// STRUCTURE
//  - Shared package pp_pipeline_accel_pkg: DIV_DIVIDEND_W=22, DIV_DIVISOR_W=11, localparam
//    DIV_CNT_W=$clog2(DIVIDEND_W), state enum {DIV_IDLE, DIV_BUSY, DIV_DONE}.
//  - Sub-module pp_pipeline_accel_udiv_step: combinational one-bit restoring step
//    (rem_in, bit_in, divisor -> rem_out, qbit). Top holds FSM, counter, operand/result registers.
// TESTING
//  1. 1000000 / 640 -> out_quot=1562, out_rem=320, out_dbz=0, out_valid at E0+22.
//  2. 0x3FFFFF / 0x7FF -> out_quot=2049, out_rem=0; 5 / 7 -> out_quot=0, out_rem=5.
//  3. 12345 / 0 -> out_dbz=1, out_quot=0x3FFFFF, out_rem=12345&0x7FF=57, same 22-cycle latency.
//  4. out_ready low 5 cycles after out_valid -> outputs and out_valid held, in_ready=0; then released.
//  5. Back-to-back, in_valid and out_ready held high -> 2nd accept on the same edge as the 1st result
//     handshake; results every 23 cycles; random 10k-op sweep vs a q=a/b, r=a%b model.
//  6. ap_rst_n pulsed low at cycle 10 of BUSY -> out_valid stays 0, all outputs 0; a fresh op after
//     release completes correctly.

Source files
------------

// File: rtl/pp_pipeline_accel_pkg.sv
// Shared definitions for the pp_pipeline_accel block: divider widths and FSM state encoding.
package pp_pipeline_accel_pkg;

  localparam int unsigned DIV_DIVIDEND_W = 22;
  localparam int unsigned DIV_DIVISOR_W  = 11;
  localparam int unsigned DIV_CNT_W      = $clog2(DIV_DIVIDEND_W);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/pp_pipeline_accel_udiv_step.sv
// One combinational restoring-division step: shift in one dividend bit, conditionally subtract.
module pp_pipeline_accel_udiv_step #(
  parameter int unsigned DIVISOR_W = 11
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0] t;

  always_comb begin
    t      = {rem_i, bit_i};
    qbit_o = (t >= {1'b0, divisor_i});
    // The difference always fits in DIVISOR_W bits, so the modulo subtraction is exact.
    rem_o  = qbit_o ? (t[DIVISOR_W-1:0] - divisor_i) : t[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/pp_pipeline_accel_udiv_22ns_11ns_seq.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
module pp_pipeline_accel_udiv_22ns_11ns_seq
  import pp_pipeline_accel_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quot,
  output logic [DIVISOR_W-1:0]  out_rem,
  output logic                  out_dbz
);

  localparam int unsigned CntW = $clog2(DIVIDEND_W);

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  rdy_en_q;
  logic                  out_valid_q, out_valid_d;
  logic [DIVIDEND_W-1:0] out_quot_q, out_quot_d;
  logic [DIVISOR_W-1:0]  out_rem_q, out_rem_d;
  logic                  out_dbz_q, out_dbz_d;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_qbit;
  logic                  accept;

  pp_pipeline_accel_udiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // rdy_en_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_en_q &&
                    ((state_q == DIV_IDLE) || ((state_q == DIV_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    out_dbz_d   = out_dbz_q;

    unique case (state_q)
      DIV_IDLE: ;
      DIV_BUSY: begin
        // Quotient bits accumulate in the low end of the dividend shift register.
        rem_d = step_rem;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_qbit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIVIDEND_W - 1)) begin
          state_d     = DIV_DONE;
          out_valid_d = 1'b1;
          out_dbz_d   = (dsr_q == '0);
          out_quot_d  = (dsr_q == '0) ? '1 : {dvd_q[DIVIDEND_W-2:0], step_qbit};
          // With a zero divisor every step keeps t, leaving the dividend's low bits here.
          out_rem_d   = step_rem;
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    if (accept) begin
      state_d = DIV_BUSY;
      cnt_d   = '0;
      dvd_d   = in_dividend;
      dsr_d   = in_divisor;
      rem_d   = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_dbz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      rdy_en_q    <= 1'b1;
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_dbz_q   <= out_dbz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign out_dbz   = out_dbz_q;

endmodule
